ahb_arbiter: RTL and testbench

- Round-robin AHB bus arbiter that shares the single AHB bus (address decoder, slave-select mux, FIR slave and register slaves) between NMST masters.
- Registers the grant, drives HGRANT and HMASTER, and provides a data-phase master index for the write-data and control muxes.
- Honours HLOCK and enforces a per-tenure beat limit so no master starves the others.
- Sits beside the address decoder in the ahb_fir top level, in front of the master-side muxes.

---
 rtl/ahb_fir_pkg.sv | 32 +++
 rtl/ahb_rr_pick.sv | 33 +++
 rtl/ahb_arbiter.sv | 138 +++++++++++++
 tb/tb_ahb_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/ahb_fir_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ahb_fir_pkg
// Purpose  : Shared types and constants for the ahb_fir bus fabric.
// Revision : 1.0 - initial release
// ============================================================================
package ahb_fir_pkg;

  localparam int NMST         = 4;
  localparam int M_ADDR_WIDTH = $clog2(NMST);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [0:0] {
    GRANTED = 1'b0,
    LOCKED  = 1'b1
  } arb_state_t;

  // (base + k) mod n for 0 <= base < n and 1 <= k <= n, valid for any n
  function automatic int wrap_inc(input int base, input int k, input int n);
    int sum;
    sum = base + k;
    return (sum >= n) ? (sum - n) : sum;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : ahb_rr_pick
// Purpose  : Combinational round-robin picker; scans from last+1 with wrap.
// Revision : 1.0 - initial release
// ============================================================================
module ahb_rr_pick
  import ahb_fir_pkg::*;
#(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  input  logic [W-1:0] dflt,
  output logic [W-1:0] idx,
  output logic         valid
);

  // Walk the ring farthest-first so the nearest requester after last wins
  always_comb begin
    idx   = dflt;
    valid = 1'b0;
    for (int k = N; k >= 1; k--) begin
      if (req[wrap_inc(int'(last), k, N)]) begin
        idx   = W'(wrap_inc(int'(last), k, N));
        valid = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ahb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ahb_arbiter
// Purpose  : Round-robin AHB arbiter with HLOCK support and tenure beat limit.
// Revision : 1.0 - initial release
// ============================================================================
module ahb_arbiter
  import ahb_fir_pkg::*;
#(
  parameter int NMST         = ahb_fir_pkg::NMST,
  parameter int M_ADDR_WIDTH = $clog2(NMST),
  parameter int MAX_BEATS    = 16,
  parameter int DEF_MASTER   = 0
) (
  input  logic                    hclk,
  input  logic                    hresetn,
  input  logic [NMST-1:0]         hbusreq,
  input  logic [NMST-1:0]         hlock,
  input  logic [1:0]              htrans,
  input  logic                    hready,
  output logic [NMST-1:0]         hgrant,
  output logic [M_ADDR_WIDTH-1:0] hmaster,
  output logic [M_ADDR_WIDTH-1:0] hmaster_dp,
  output logic                    hmastlock
);

  localparam int                     c_beat_w    = $clog2(MAX_BEATS + 1);
  localparam logic [c_beat_w-1:0]     c_max_beats = c_beat_w'(MAX_BEATS);
  localparam logic [M_ADDR_WIDTH-1:0] c_def       = M_ADDR_WIDTH'(DEF_MASTER);

  arb_state_t              r_state;
  arb_state_t              w_state_nxt;
  logic [M_ADDR_WIDTH-1:0] r_grant_idx;
  logic [M_ADDR_WIDTH-1:0] r_last;
  logic [M_ADDR_WIDTH-1:0] r_hmaster;
  logic [M_ADDR_WIDTH-1:0] r_hmaster_dp;
  logic                    r_hmastlock;
  logic [c_beat_w-1:0]     r_beat_cnt;

  logic [M_ADDR_WIDTH-1:0] w_grant_nxt;
  logic [M_ADDR_WIDTH-1:0] w_last_nxt;
  logic [M_ADDR_WIDTH-1:0] w_pick_idx;
  logic                    w_pick_valid;
  logic                    w_rearb;
  htrans_t                 w_htrans;
  logic                    w_owner_req;
  logic                    w_owner_lock;
  logic                    w_other_req;
  logic                    w_beat_max;

  assign w_htrans     = htrans_t'(htrans);
  assign w_owner_req  = hbusreq[r_grant_idx];
  assign w_owner_lock = hlock[r_grant_idx];
  assign w_other_req  = |(hbusreq & ~hgrant);
  assign w_beat_max   = (r_beat_cnt >= c_max_beats);

  ahb_rr_pick #(
    .N (NMST),
    .W (M_ADDR_WIDTH)
  ) u_pick (
    .req   (hbusreq),
    .last  (r_last),
    .dflt  (c_def),
    .idx   (w_pick_idx),
    .valid (w_pick_valid)
  );

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_state      <= GRANTED;
      r_grant_idx  <= c_def;
      r_last       <= c_def;
      r_hmaster    <= c_def;
      r_hmaster_dp <= c_def;
      r_hmastlock  <= 1'b0;
      r_beat_cnt   <= '0;
    end else if (hready) begin
      r_state      <= w_state_nxt;
      r_grant_idx  <= w_grant_nxt;
      r_last       <= w_last_nxt;
      r_hmaster    <= r_grant_idx;
      r_hmaster_dp <= r_hmaster;
      r_hmastlock  <= w_owner_lock;
      // The beat finishing on an owner change belongs to the old master
      if (r_grant_idx != r_hmaster) begin
        r_beat_cnt <= '0;
      end else if ((w_htrans == NONSEQ || w_htrans == SEQ) && !w_beat_max) begin
        r_beat_cnt <= r_beat_cnt + c_beat_w'(1);
      end
    end
  end

  // Lock takes priority over every handover trigger
  always_comb begin
    w_state_nxt = r_state;
    w_rearb     = 1'b0;
    if (hready) begin
      case (r_state)
        GRANTED: begin
          if (w_owner_lock) begin
            w_state_nxt = LOCKED;
          end else if (!w_owner_req || (w_htrans == IDLE) ||
                       (w_beat_max && w_other_req)) begin
            w_rearb = 1'b1;
          end
        end
        LOCKED: begin
          if (!w_owner_lock && (w_htrans == IDLE)) begin
            w_state_nxt = GRANTED;
            w_rearb     = 1'b1;
          end
        end
        default: w_state_nxt = GRANTED;
      endcase
    end
  end

  always_comb begin
    w_grant_nxt = r_grant_idx;
    w_last_nxt  = r_last;
    if (w_rearb) begin
      w_grant_nxt = w_pick_valid ? w_pick_idx : c_def;
      if (w_grant_nxt != r_grant_idx) begin
        w_last_nxt = w_grant_nxt;
      end
    end
  end

  for (genvar i = 0; i < NMST; i++) begin : g_grant
    assign hgrant[i] = (r_grant_idx == M_ADDR_WIDTH'(i));
  end

  assign hmaster    = r_hmaster;
  assign hmaster_dp = r_hmaster_dp;
  assign hmastlock  = r_hmastlock;

endmodule
`default_nettype wire

// File: tb/tb_ahb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_arbiter
// Purpose  : Directed scoreboard bench for ahb_arbiter (NMST=4 and NMST=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ahb_arbiter;
  import ahb_fir_pkg::*;

  logic       hclk = 1'b0;
  logic       hresetn;
  logic [3:0] hbusreq, hlock;
  logic [1:0] htrans;
  logic       hready;
  logic [3:0] hgrant;
  logic [1:0] hmaster, hmaster_dp;
  logic       hmastlock;

  logic [2:0] b3_hbusreq, b3_hlock;
  logic [1:0] b3_htrans;
  logic       b3_hready;
  logic [2:0] b3_hgrant;
  logic [1:0] b3_hmaster, b3_hmaster_dp;
  logic       b3_hmastlock;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string      tag;
    int         inst;
    logic [3:0] grant;
    logic [1:0] hm;
    logic [1:0] dp;
    logic       lk;
  } exp_t;

  exp_t sb[$];

  always #5 hclk = ~hclk;

  ahb_arbiter #(.NMST(4), .MAX_BEATS(16), .DEF_MASTER(0)) dut (
    .hclk       (hclk),
    .hresetn    (hresetn),
    .hbusreq    (hbusreq),
    .hlock      (hlock),
    .htrans     (htrans),
    .hready     (hready),
    .hgrant     (hgrant),
    .hmaster    (hmaster),
    .hmaster_dp (hmaster_dp),
    .hmastlock  (hmastlock)
  );

  ahb_arbiter #(.NMST(3), .MAX_BEATS(16), .DEF_MASTER(0)) dut3 (
    .hclk       (hclk),
    .hresetn    (hresetn),
    .hbusreq    (b3_hbusreq),
    .hlock      (b3_hlock),
    .htrans     (b3_htrans),
    .hready     (b3_hready),
    .hgrant     (b3_hgrant),
    .hmaster    (b3_hmaster),
    .hmaster_dp (b3_hmaster_dp),
    .hmastlock  (b3_hmastlock)
  );

  function automatic logic [3:0] oh(input int i);
    logic [3:0] v;
    v = 4'b0001;
    return v << i;
  endfunction

  task automatic push_exp(input string tag, input int inst, input logic [3:0] g,
                          input logic [1:0] hm, input logic [1:0] dp, input logic lk);
    exp_t e;
    e.tag = tag; e.inst = inst; e.grant = g; e.hm = hm; e.dp = dp; e.lk = lk;
    sb.push_back(e);
  endtask

  task automatic check_front();
    exp_t e;
    logic [3:0] og;
    logic [1:0] ohm, odp;
    logic       olk;
    if (sb.size() == 0) begin
      n_tests++; n_fail++;
      $error("FAIL scoreboard_empty observed=0 entries required=1");
      return;
    end
    e = sb.pop_front();
    if (e.inst == 0) begin
      og = hgrant; ohm = hmaster; odp = hmaster_dp; olk = hmastlock;
    end else begin
      og = {1'b0, b3_hgrant}; ohm = b3_hmaster; odp = b3_hmaster_dp; olk = b3_hmastlock;
    end
    n_tests++;
    assert (og === e.grant) else begin
      n_fail++; $error("FAIL %s hgrant observed=%b expected=%b", e.tag, og, e.grant);
    end
    n_tests++;
    assert (ohm === e.hm) else begin
      n_fail++; $error("FAIL %s hmaster observed=%0d expected=%0d", e.tag, ohm, e.hm);
    end
    n_tests++;
    assert (odp === e.dp) else begin
      n_fail++; $error("FAIL %s hmaster_dp observed=%0d expected=%0d", e.tag, odp, e.dp);
    end
    n_tests++;
    assert (olk === e.lk) else begin
      n_fail++; $error("FAIL %s hmastlock observed=%b expected=%b", e.tag, olk, e.lk);
    end
  endtask

  task automatic step(input string tag, input int inst, input logic [3:0] g,
                      input logic [1:0] hm, input logic [1:0] dp, input logic lk);
    push_exp(tag, inst, g, hm, dp, lk);
    @(posedge hclk);
    #1;
    check_front();
  endtask

  task automatic do_reset();
    hresetn    = 1'b0;
    hbusreq    = '0; hlock = '0; htrans = IDLE; hready = 1'b1;
    b3_hbusreq = '0; b3_hlock = '0; b3_htrans = IDLE; b3_hready = 1'b1;
    step("reset", 0, 4'b0001, 2'd0, 2'd0, 1'b0);
    hresetn = 1'b1;
  endtask

  initial begin
    do_reset();

    // Basic round robin and pipeline latency
    hbusreq = 4'b0110; htrans = IDLE;
    step("rr_grant_m1", 0, oh(1), 2'd0, 2'd0, 1'b0);
    htrans = NONSEQ;
    step("rr_hmaster_m1", 0, oh(1), 2'd1, 2'd0, 1'b0);
    step("rr_dp_m1", 0, oh(1), 2'd1, 2'd1, 1'b0);
    hbusreq = 4'b0100; htrans = IDLE;
    step("rr_drop_m1", 0, oh(2), 2'd1, 2'd1, 1'b0);
    htrans = NONSEQ;
    step("rr_hmaster_m2", 0, oh(2), 2'd2, 2'd1, 1'b0);
    step("rr_dp_m2", 0, oh(2), 2'd2, 2'd2, 1'b0);
    hbusreq = 4'b0000; htrans = IDLE;
    step("rr_none_def", 0, oh(0), 2'd2, 2'd2, 1'b0);
    step("rr_none_hm", 0, oh(0), 2'd0, 2'd2, 1'b0);
    step("rr_none_dp", 0, oh(0), 2'd0, 2'd0, 1'b0);

    // Asynchronous reset mid-burst with grant at M2
    hbusreq = 4'b0100;
    step("ar_grant_m2", 0, oh(2), 2'd0, 2'd0, 1'b0);
    htrans = NONSEQ;
    step("ar_burst", 0, oh(2), 2'd2, 2'd0, 1'b0);
    step("ar_burst2", 0, oh(2), 2'd2, 2'd2, 1'b0);
    hresetn = 1'b0;
    #2;
    push_exp("async_reset", 0, 4'b0001, 2'd0, 2'd0, 1'b0);
    check_front();
    @(posedge hclk); #1;
    hbusreq = '0; htrans = IDLE; hresetn = 1'b1;

    // Beat limit with BUSY cycles that must not count
    hbusreq = 4'b1010; htrans = IDLE;
    step("bl_grant_m1", 0, oh(1), 2'd0, 2'd0, 1'b0);
    htrans = NONSEQ;
    step("bl_first", 0, oh(1), 2'd1, 2'd0, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      if (i == 5 || i == 11) begin
        htrans = BUSY;
        step("bl_busy", 0, oh(1), 2'd1, 2'd1, 1'b0);
      end
      htrans = SEQ;
      step("bl_beat", 0, oh(1), 2'd1, 2'd1, 1'b0);
    end
    step("bl_handover", 0, oh(3), 2'd1, 2'd1, 1'b0);

    // Locked tenure outlasts the beat limit and survives an hbusreq drop
    do_reset();
    hbusreq = 4'b0100; htrans = IDLE;
    step("lk_grant_m2", 0, oh(2), 2'd0, 2'd0, 1'b0);
    hbusreq = 4'b0111; hlock = 4'b0100; htrans = NONSEQ;
    step("lk_enter", 0, oh(2), 2'd2, 2'd0, 1'b1);
    for (int i = 0; i < 40; i++) begin
      htrans  = SEQ;
      hbusreq = (i >= 20 && i < 26) ? 4'b0011 : 4'b0111;
      step("lk_burst", 0, oh(2), 2'd2, 2'd2, 1'b1);
    end
    hlock = 4'b0000;
    step("lk_unlock_busy", 0, oh(2), 2'd2, 2'd2, 1'b0);
    htrans = IDLE;
    step("lk_release", 0, oh(0), 2'd2, 2'd2, 1'b0);

    // Wait states freeze grant and pipeline
    do_reset();
    hbusreq = 4'b0010; htrans = IDLE;
    step("hr_grant_m1", 0, oh(1), 2'd0, 2'd0, 1'b0);
    hready = 1'b0; hbusreq = 4'b1000; htrans = NONSEQ;
    for (int i = 0; i < 5; i++) begin
      step("hr_frozen", 0, oh(1), 2'd0, 2'd0, 1'b0);
    end
    hready = 1'b1;
    step("hr_handover", 0, oh(3), 2'd1, 2'd0, 1'b0);

    // NMST=3 wrap from last=2 to M0
    do_reset();
    b3_hbusreq = 3'b100;
    step("w3_grant_m2", 1, 4'b0100, 2'd0, 2'd0, 1'b0);
    b3_hbusreq = 3'b011;
    step("w3_wrap_m0", 1, 4'b0001, 2'd2, 2'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
